alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage of the 8-bit single-cycle CPU.
- Conditions the second operand: optional two's-complement negation, then selects between register value and immediate.
- Performs the 8-bit ALU operation selected by ALUOP and produces the ZERO flag.
- Selects next-PC (sequential vs jump/branch target) and holds the 32-bit PC register.

Parameters:
- DATA_W, 8, ALU operand/result width
- PC_W, 32, program counter width

Ports:
- CLK  in  1  system clock, rising-edge active
- RESET  in  1  asynchronous, active-low reset
- DATA1  in  8  operand 1 (register file OUT1)
- REGOUT2  in  8  register file OUT2
- IMMEDIATE  in  8  instruction immediate field [7:0]
- NEGSELECT  in  1  1 = use two's complement of REGOUT2
- IMSELECT  in  1  1 = operand 2 is IMMEDIATE, 0 = (negated) REGOUT2
- ALUOP  in  3  operation select
- PCADDED  in  32  PC+4 (sequential next PC)
- PCADDED_J_BEQ  in  32  jump/branch target
- JUMPSELECT  in  1  unconditional jump
- BEQSELECT  in  1  branch if equal
- BNESELECT  in  1  branch if not equal
- ALURESULT  out  8  ALU result (combinational)
- ZERO  out  1  ALURESULT == 0 (combinational)
- PCUPDATED  out  32  selected next PC (combinational)
- PC  out  32  registered program counter

Behaviour:
Operand path (combinational):
- NEGOUT = NEGSELECT ? (~REGOUT2 + 1) mod 256 : REGOUT2.
- DATA2 = IMSELECT ? IMMEDIATE : NEGOUT.

ALU (combinational, mod 256):
- 000 FORWARD: DATA2
- 001 ADD: DATA1 + DATA2, carry discarded
- 010 AND: DATA1 & DATA2
- 011 OR: DATA1 | DATA2
- 100 MULT: low 8 bits of DATA1 * DATA2 (unsigned)
- 101 SLL: DATA1 << DATA2; shift amount >= 8 gives 0
- 110 SRL: DATA1 >> DATA2, zero fill; amount >= 8 gives 0
- 111 SRA: DATA1 >> DATA2, fill with DATA1[7]; amount >= 8 gives all bits = DATA1[7]

ZERO:
- ZERO = (ALURESULT == 0) for every opcode.

Next-PC select:
- TAKE = JUMPSELECT | (BEQSELECT & ZERO) | (BNESELECT & ~ZERO).
- PCUPDATED = TAKE ? PCADDED_J_BEQ : PCADDED.
- Multiple select lines asserted: the OR rule applies, with no priority.

PC register:
- RESET low: PC = 0 immediately, asynchronously, independent of CLK.
- Otherwise PC <= PCUPDATED on each CLK rising edge.
- RESET deasserting between edges: the first update is on the next rising edge.
- RESET asserted mid-cycle forces PC to 0 at once and holds it at 0 while low.

General:
- No #delays in the RTL.
- All outputs other than PC follow their inputs within the same cycle.

Decomposition:
- Shared package (cpu_pkg): ALUOP localparams (ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_MUL, ALU_SLL, ALU_SRL, ALU_SRA), DATA_W, PC_W.
- One sub-module, alu8: DATA1, DATA2, ALUOP in; result and ZERO out.
- Operand muxes, next-PC mux and PC register stay inline in alu_exec_stage.

Test Plan:
1. Reset: RESET=0 mid-cycle with PC=0x10 -> PC=0 immediately, before any CLK edge; after release, PCADDED=4 and no branch selects -> PC=4 after one edge.
2. Operand path: REGOUT2=0x05, NEGSELECT=1, IMSELECT=0, ALUOP=001, DATA1=0x05 -> ALURESULT=0x00, ZERO=1. Then IMSELECT=1, IMMEDIATE=0x7F, ALUOP=000 -> ALURESULT=0x7F, ZERO=0.
3. Arithmetic/logic: DATA1=0xC8, DATA2=0x64 -> ADD gives 0x2C (wrap). DATA1=0xF0, DATA2=0x3C -> AND 0x30, OR 0xFC. DATA1=0x10, DATA2=0x11 -> MULT 0x10.
4. Shifts: DATA1=0x81 -> SLL by 1 = 0x02, SRL by 1 = 0x40, SRA by 1 = 0xC0, SRA by 9 = 0xFF, SLL by 8 = 0x00.
5. Branches: PCADDED=0x08, PCADDED_J_BEQ=0x20. BEQSELECT=1 with ZERO=1 -> PCUPDATED=0x20, PC=0x20 after the edge. BEQSELECT=1 with ZERO=0 -> 0x08. BNESELECT=1 with ZERO=0 -> 0x20.
6. Jump: JUMPSELECT=1 regardless of ZERO -> PCUPDATED=0x20. All selects 0 -> 0x08.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit single-cycle CPU.
// ALU opcodes and datapath widths.
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int PC_W   = 32;

   localparam logic [2:0] ALU_FWD = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_MUL = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SRA = 3'b111;

endpackage

// File: rtl/alu8.sv
// 8-bit combinational ALU with zero flag.
// Shift amounts use the full operand, so amounts >= 8 saturate.
module alu8
   import cpu_pkg::*;
(
   input  logic [DATA_W-1:0] DATA1,
   input  logic [DATA_W-1:0] DATA2,
   input  logic [2:0]        ALUOP,
   output logic [DATA_W-1:0] RESULT,
   output logic              ZERO
);

   logic [2*DATA_W-1:0] w_prod;
   logic [DATA_W-1:0]   w_sra;

   assign w_prod = (2*DATA_W)'(DATA1) * (2*DATA_W)'(DATA2);
   assign w_sra  = DATA_W'($signed(DATA1) >>> DATA2);

   always_comb begin
      RESULT = '0;
      unique case (ALUOP)
         ALU_FWD: RESULT = DATA2;
         ALU_ADD: RESULT = DATA1 + DATA2;
         ALU_AND: RESULT = DATA1 & DATA2;
         ALU_OR:  RESULT = DATA1 | DATA2;
         ALU_MUL: RESULT = w_prod[DATA_W-1:0];
         ALU_SLL: RESULT = DATA1 << DATA2;
         ALU_SRL: RESULT = DATA1 >> DATA2;
         ALU_SRA: RESULT = w_sra;
      endcase
   end

   assign ZERO = (RESULT == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: operand conditioning, ALU, next-PC select
// and the program counter register.
module alu_exec_stage
   import cpu_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] DATA1,
   input  logic [DATA_W-1:0] REGOUT2,
   input  logic [DATA_W-1:0] IMMEDIATE,
   input  logic              NEGSELECT,
   input  logic              IMSELECT,
   input  logic [2:0]        ALUOP,
   input  logic [PC_W-1:0]   PCADDED,
   input  logic [PC_W-1:0]   PCADDED_J_BEQ,
   input  logic              JUMPSELECT,
   input  logic              BEQSELECT,
   input  logic              BNESELECT,
   output logic [DATA_W-1:0] ALURESULT,
   output logic              ZERO,
   output logic [PC_W-1:0]   PCUPDATED,
   output logic [PC_W-1:0]   PC
);

   logic [DATA_W-1:0] w_negout;
   logic [DATA_W-1:0] w_data2;
   logic              w_take;

   assign w_negout = NEGSELECT ? (~REGOUT2 + 1'b1) : REGOUT2;
   assign w_data2  = IMSELECT ? IMMEDIATE : w_negout;

   alu8 u_alu (
      .DATA1  (DATA1),
      .DATA2  (w_data2),
      .ALUOP  (ALUOP),
      .RESULT (ALURESULT),
      .ZERO   (ZERO)
   );

   // Select lines combine by OR; no priority between them.
   assign w_take = JUMPSELECT
                 | (BEQSELECT & ZERO)
                 | (BNESELECT & ~ZERO);

   assign PCUPDATED = w_take ? PCADDED_J_BEQ : PCADDED;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) PC <= '0;
      else        PC <= PCUPDATED;
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and randomized checks of alu_exec_stage using
// an expected-value queue drained once outputs settle.
module tb_alu_exec_stage;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  DATA1, REGOUT2, IMMEDIATE;
   logic        NEGSELECT, IMSELECT;
   logic [2:0]  ALUOP;
   logic [31:0] PCADDED, PCADDED_J_BEQ;
   logic        JUMPSELECT, BEQSELECT, BNESELECT;
   logic [7:0]  ALURESULT;
   logic        ZERO;
   logic [31:0] PCUPDATED, PC;

   alu_exec_stage dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .DATA1         (DATA1),
      .REGOUT2       (REGOUT2),
      .IMMEDIATE     (IMMEDIATE),
      .NEGSELECT     (NEGSELECT),
      .IMSELECT      (IMSELECT),
      .ALUOP         (ALUOP),
      .PCADDED       (PCADDED),
      .PCADDED_J_BEQ (PCADDED_J_BEQ),
      .JUMPSELECT    (JUMPSELECT),
      .BEQSELECT     (BEQSELECT),
      .BNESELECT     (BNESELECT),
      .ALURESULT     (ALURESULT),
      .ZERO          (ZERO),
      .PCUPDATED     (PCUPDATED),
      .PC            (PC)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] val;
   } chk_t;

   chk_t sbq[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   localparam int K_ALU = 0;
   localparam int K_Z   = 1;
   localparam int K_NPC = 2;
   localparam int K_PC  = 3;

   task automatic push(input string tag, input int kind,
                       input logic [31:0] v);
      chk_t c;
      c.tag  = tag;
      c.kind = kind;
      c.val  = v;
      sbq.push_back(c);
   endtask

   task automatic drain();
      chk_t        c;
      logic [31:0] obs;
      #1;
      while (sbq.size() > 0) begin
         c = sbq.pop_front();
         case (c.kind)
            K_ALU:   obs = {24'h0, ALURESULT};
            K_Z:     obs = {31'h0, ZERO};
            K_NPC:   obs = PCUPDATED;
            default: obs = PC;
         endcase
         n_tot++;
         assert (obs === c.val) n_pass++;
         else $error("FAIL %s observed=%h expected=%h",
                     c.tag, obs, c.val);
      end
   endtask

   task automatic set_alu(input logic [7:0] d1, input logic [7:0] r2,
                          input logic [7:0] imm, input logic neg,
                          input logic ims, input logic [2:0] op);
      DATA1 = d1; REGOUT2 = r2; IMMEDIATE = imm;
      NEGSELECT = neg; IMSELECT = ims; ALUOP = op;
   endtask

   task automatic set_sel(input logic j, input logic beq,
                          input logic bne);
      JUMPSELECT = j; BEQSELECT = beq; BNESELECT = bne;
   endtask

   // Reference ALU: shifts by iteration, multiply by shift-and-add
   function automatic logic [7:0] model(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      case (op)
         3'd0: r = b;
         3'd1: r = a + b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: for (int i = 0; i < 8; i++)
                  if (b[i]) r = r + (a << i);
         3'd5: begin
            r = a;
            for (int i = 0; i < 256; i++)
               if (i < int'(b)) r = {r[6:0], 1'b0};
         end
         3'd6: begin
            r = a;
            for (int i = 0; i < 256; i++)
               if (i < int'(b)) r = {1'b0, r[7:1]};
         end
         default: begin
            r = a;
            for (int i = 0; i < 256; i++)
               if (i < int'(b)) r = {a[7], r[7:1]};
         end
      endcase
      return r;
   endfunction

   initial begin
      logic [7:0]  d1, r2, imm, d2, res;
      logic [2:0]  op;
      logic        neg, ims, j, beq, bne, take;

      RESET = 1'b0;
      set_alu(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
      set_sel(1'b0, 1'b0, 1'b0);
      PCADDED = 32'h10; PCADDED_J_BEQ = 32'h20;
      push("pc_in_reset", K_PC, 32'h0);
      drain();

      // Load PC=0x10, then assert reset mid-cycle
      @(negedge CLK); RESET = 1'b1;
      @(posedge CLK);
      push("pc_load_10", K_PC, 32'h10);
      drain();
      #2 RESET = 1'b0;
      push("pc_async_rst", K_PC, 32'h0);
      drain();
      @(negedge CLK); RESET = 1'b1; PCADDED = 32'h4;
      @(posedge CLK);
      push("pc_after_rst", K_PC, 32'h4);
      drain();

      // Operand path
      @(negedge CLK);
      set_alu(8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 3'd1);
      push("neg_add", K_ALU, 32'h00);
      push("neg_add_z", K_Z, 32'h1);
      drain();
      set_alu(8'h05, 8'h05, 8'h7F, 1'b1, 1'b1, 3'd0);
      push("imm_fwd", K_ALU, 32'h7F);
      push("imm_fwd_z", K_Z, 32'h0);
      drain();

      // Arithmetic / logic via immediate operand
      set_alu(8'hC8, 8'h00, 8'h64, 1'b0, 1'b1, 3'd1);
      push("add_wrap", K_ALU, 32'h2C);
      drain();
      set_alu(8'hF0, 8'h00, 8'h3C, 1'b0, 1'b1, 3'd2);
      push("and", K_ALU, 32'h30);
      drain();
      ALUOP = 3'd3;
      push("or", K_ALU, 32'hFC);
      drain();
      set_alu(8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 3'd4);
      push("mul", K_ALU, 32'h10);
      drain();

      // Shifts
      set_alu(8'h81, 8'h01, 8'h00, 1'b0, 1'b0, 3'd5);
      push("sll1", K_ALU, 32'h02);
      drain();
      ALUOP = 3'd6;
      push("srl1", K_ALU, 32'h40);
      drain();
      ALUOP = 3'd7;
      push("sra1", K_ALU, 32'hC0);
      drain();
      REGOUT2 = 8'h09;
      push("sra9", K_ALU, 32'hFF);
      drain();
      REGOUT2 = 8'h08; ALUOP = 3'd5;
      push("sll8", K_ALU, 32'h00);
      push("sll8_z", K_Z, 32'h1);
      drain();

      // Branches
      PCADDED = 32'h08; PCADDED_J_BEQ = 32'h20;
      set_alu(8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 3'd1);
      set_sel(1'b0, 1'b1, 1'b0);
      push("beq_taken", K_NPC, 32'h20);
      drain();
      @(posedge CLK);
      push("beq_pc", K_PC, 32'h20);
      drain();
      @(negedge CLK);
      set_alu(8'h05, 8'h03, 8'h00, 1'b0, 1'b0, 3'd1);
      push("beq_not", K_NPC, 32'h08);
      drain();
      set_sel(1'b0, 1'b0, 1'b1);
      push("bne_taken", K_NPC, 32'h20);
      drain();
      set_alu(8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 3'd1);
      push("bne_not", K_NPC, 32'h08);
      drain();
      set_sel(1'b1, 1'b0, 1'b0);
      push("jump_z", K_NPC, 32'h20);
      drain();
      set_alu(8'h05, 8'h01, 8'h00, 1'b0, 1'b0, 3'd1);
      push("jump_nz", K_NPC, 32'h20);
      drain();
      set_sel(1'b0, 1'b1, 1'b1);
      push("beq_bne_or", K_NPC, 32'h20);
      drain();
      set_sel(1'b0, 1'b0, 1'b0);
      push("no_sel", K_NPC, 32'h08);
      drain();
      @(posedge CLK);
      push("seq_pc", K_PC, 32'h08);
      drain();

      // Randomized sweep against the reference model
      for (int n = 0; n < 40; n++) begin
         @(negedge CLK);
         d1 = 8'($urandom); r2 = 8'($urandom); imm = 8'($urandom);
         neg = 1'($urandom); ims = 1'($urandom); op = 3'($urandom);
         j = 1'($urandom); beq = 1'($urandom); bne = 1'($urandom);
         if (n % 4 == 0) r2 = 8'($urandom_range(0, 12));
         set_alu(d1, r2, imm, neg, ims, op);
         set_sel(j, beq, bne);
         PCADDED = $urandom; PCADDED_J_BEQ = $urandom;
         d2 = ims ? imm : (neg ? 8'(0 - int'(r2)) : r2);
         res = model(op, d1, d2);
         take = j | (beq & (res == 8'h00)) | (bne & (res != 8'h00));
         push("rnd_alu", K_ALU, {24'h0, res});
         push("rnd_z", K_Z, {31'h0, res == 8'h00});
         push("rnd_npc", K_NPC, take ? PCADDED_J_BEQ : PCADDED);
         drain();
         @(posedge CLK);
         push("rnd_pc", K_PC, take ? PCADDED_J_BEQ : PCADDED);
         drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
